shunting_yard: RTL and testbench
================================

# shunting_yard

Parametrised infix-to-postfix token converter implementing the shunting-yard algorithm with an internal operator stack. It adds parentheses, a right-associative power operator, error detection and valid/ready flow control on both sides. It sits between the expression tokenizer and the postfix evaluator, consuming one infix token stream and producing one postfix token stream per expression.

## Interface
- DATA_W, 8, width of number tokens and of OUT_DATA (must be ≥ 8)
- DEPTH, 16, operator stack entries (≥ 2)
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- IN_VALID  in  1  input token valid
- IN_READY  out  1  input token accepted when IN_VALID & IN_READY
- IN_TYPE  in  3  0=NUM, 1=OP, 2=LPAR, 3=RPAR, 4=END; 5–7 are illegal
- IN_DATA  in  DATA_W  number value (NUM) or ASCII operator in bits [7:0] (OP)
- OUT_VALID  out  1  output token valid; held until OUT_READY
- OUT_READY  in  1  downstream accept
- OUT_IS_OP  out  1  1 = OUT_DATA[7:0] is an ASCII operator, 0 = number
- OUT_DATA  out  DATA_W  token value, operators zero-extended
- DONE  out  1  one-cycle pulse after the last postfix token of an END-terminated expression is accepted
- BUSY  out  1  high whenever state ≠ IDLE or OUT_VALID=1
- ERR  out  1  sticky error flag, cleared only by RST
- ERR_CODE  out  2  1=stack overflow, 2=paren mismatch, 3=illegal op/type

## Operation
- Operators and precedence: '+','-' = 1 (left); '*','/' = 2 (left); '^' = 3 (right). Any other OP byte, or IN_TYPE 5–7, raises ERR code 3.
- Stack: register array of DEPTH × 3-bit codes (+,-,*,/,^,LPAR), plus a counter of width $clog2(DEPTH+1).
- Output register: loaded when it is free (OUT_VALID=0, or OUT_VALID & OUT_READY in the same cycle).
- States:
  - IDLE: IN_READY = output register free. Accepted token:
    - NUM is loaded into the output register (OUT_IS_OP=0); stay in IDLE.
    - OP is latched into the pending register; go to CMP.
    - LPAR is pushed; stay in IDLE.
    - RPAR goes to PAREN.
    - END goes to DRAIN.
  - CMP: if the stack is empty, or top = LPAR, or prec(top) < prec(pend), or (prec equal and pend = '^'), push pend and go to IDLE. Otherwise pop top into the output register (stalls while the register is not free) and stay in CMP.
  - PAREN: empty stack gives ERR code 2. Top = LPAR is popped and discarded, then go to IDLE. Any other top is popped and emitted; stay in PAREN.
  - DRAIN: empty stack waits for the output register to be free, then pulses DONE and goes to IDLE. Top = LPAR gives ERR code 2. Any other top is popped and emitted.
  - ERROR: IN_READY=0, OUT_VALID=0, no stack activity until RST.
- Overflow: a push with count = DEPTH does not write the stack and gives ERR code 1.
- Error entry: ERR and ERR_CODE are set in the cycle the condition is detected, and the state becomes ERROR. A pending output token is discarded.
- Reset mid-expression: the stack, pending register and output register are all discarded.

## Timing
- Reset values: IN_READY=0 while RST=1, OUT_VALID=0, OUT_IS_OP=0, OUT_DATA=0, DONE=0, BUSY=0, ERR=0, ERR_CODE=0. State becomes IDLE and count=0. IN_READY rises in the first cycle after RST falls.
- NUM throughput: 1 token/cycle with OUT_READY=1. OUT_VALID rises the cycle after acceptance.
- OP with no pops: accepted in cycle n, pushed in cycle n+1, IN_READY high again in n+2.
- Each pop-and-emit takes 1 cycle when the output register is free.
- OUT_DATA and OUT_IS_OP are stable while OUT_VALID=1 and OUT_READY=0.
- DONE pulses in the cycle after the last token's handshake. It pulses in the cycle after END acceptance for an empty expression.
- Stack indexing: top = stack[count-1]. A push writes stack[count]. Pointers never wrap; overflow is an error, and underflow is only reachable via RPAR or DRAIN on an empty stack, which is handled above.

## Test plan
- 3 + 4 * 2 END with OUT_READY=1 -> 3 4 2 * + then a DONE pulse; stack count 0.
- ( 1 + 2 ) * 3 END -> 1 2 + 3 *; 8 - 4 - 2 END -> 8 4 - 2 -; 2 ^ 3 ^ 2 END -> 2 3 2 ^ ^.
- OUT_READY toggled randomly (50%) during 7 + 6 * ( 5 - 1 ) END -> identical sequence 7 6 5 1 - * +, no token dropped or duplicated, OUT_DATA stable while stalled.
- DEPTH=2: ( ( ( -> third LPAR gives ERR=1, ERR_CODE=1; IN_READY stays 0; RST then 1 + 1 END -> 1 1 +.
- RPAR with empty stack -> ERR_CODE=2; separately ( 1 END -> 1 emitted, then ERR_CODE=2 in DRAIN.
- OP byte '%' -> ERR_CODE=3; RST asserted mid-DRAIN of 1+2*3 -> all outputs at reset values next cycle, count 0.

Source files
------------

// File: rtl/shunting_yard.sv
// Infix-to-postfix token converter (shunting-yard) with an internal operator stack,
// parenthesis handling, right-associative power and valid/ready flow control.
module shunting_yard #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [2:0]        IN_TYPE,
   input  logic [DATA_W-1:0] IN_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic              OUT_IS_OP,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic              DONE,
   output logic              BUSY,
   output logic              ERR,
   output logic [1:0]        ERR_CODE
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [2:0] C_ADD  = 3'd0;
   localparam logic [2:0] C_SUB  = 3'd1;
   localparam logic [2:0] C_MUL  = 3'd2;
   localparam logic [2:0] C_DIV  = 3'd3;
   localparam logic [2:0] C_POW  = 3'd4;
   localparam logic [2:0] C_LPAR = 3'd5;

   localparam logic [2:0] T_NUM  = 3'd0;
   localparam logic [2:0] T_OP   = 3'd1;
   localparam logic [2:0] T_LPAR = 3'd2;
   localparam logic [2:0] T_RPAR = 3'd3;
   localparam logic [2:0] T_END  = 3'd4;

   localparam logic [1:0] E_OVF   = 2'd1;
   localparam logic [1:0] E_PAREN = 2'd2;
   localparam logic [1:0] E_ILL   = 2'd3;

   typedef enum logic [2:0] {S_IDLE, S_CMP, S_PAREN, S_DRAIN, S_ERROR} state_t;

   state_t           state;
   logic [2:0]       stack [DEPTH];
   logic [CNT_W-1:0] cnt;
   logic [2:0]       pend;

   function automatic logic [1:0] prec(input logic [2:0] code);
      case (code)
         C_ADD, C_SUB: prec = 2'd1;
         C_MUL, C_DIV: prec = 2'd2;
         C_POW:        prec = 2'd3;
         default:      prec = 2'd0;
      endcase
   endfunction

   function automatic logic [7:0] op_ascii(input logic [2:0] code);
      case (code)
         C_ADD:   op_ascii = 8'h2B;
         C_SUB:   op_ascii = 8'h2D;
         C_MUL:   op_ascii = 8'h2A;
         C_DIV:   op_ascii = 8'h2F;
         C_POW:   op_ascii = 8'h5E;
         default: op_ascii = 8'h28;
      endcase
   endfunction

   logic       out_free;
   logic       stack_empty;
   logic       stack_full;
   logic [2:0] top;
   logic       pend_wins;
   logic [2:0] in_code;
   logic       in_legal;
   logic       accept;

   assign out_free    = !OUT_VALID || OUT_READY;
   assign stack_empty = (cnt == '0);
   assign stack_full  = (cnt == CNT_W'(DEPTH));
   assign top         = stack[PTR_W'(cnt - CNT_W'(1))];
   assign pend_wins   = stack_empty || (top == C_LPAR) || (prec(top) < prec(pend)) ||
                        ((prec(top) == prec(pend)) && (pend == C_POW));
   assign IN_READY    = !RST && (state == S_IDLE) && out_free;
   assign accept      = IN_VALID && IN_READY;
   assign BUSY        = (state != S_IDLE) || OUT_VALID;

   // Operator byte decode
   always_comb begin
      in_code  = C_ADD;
      in_legal = 1'b1;
      case (IN_DATA[7:0])
         8'h2B:   in_code = C_ADD;
         8'h2D:   in_code = C_SUB;
         8'h2A:   in_code = C_MUL;
         8'h2F:   in_code = C_DIV;
         8'h5E:   in_code = C_POW;
         default: in_legal = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         cnt       <= '0;
         pend      <= C_ADD;
         OUT_VALID <= 1'b0;
         OUT_IS_OP <= 1'b0;
         OUT_DATA  <= '0;
         DONE      <= 1'b0;
         ERR       <= 1'b0;
         ERR_CODE  <= 2'd0;
      end else begin
         DONE <= 1'b0;
         if (OUT_VALID && OUT_READY)
            OUT_VALID <= 1'b0;
         case (state)
            S_IDLE: if (accept) begin
               case (IN_TYPE)
                  T_NUM: begin
                     OUT_VALID <= 1'b1;
                     OUT_IS_OP <= 1'b0;
                     OUT_DATA  <= IN_DATA;
                  end
                  T_OP: if (in_legal) begin
                     pend  <= in_code;
                     state <= S_CMP;
                  end else begin
                     state <= S_ERROR; ERR <= 1'b1; ERR_CODE <= E_ILL; OUT_VALID <= 1'b0;
                  end
                  T_LPAR: if (stack_full) begin
                     state <= S_ERROR; ERR <= 1'b1; ERR_CODE <= E_OVF; OUT_VALID <= 1'b0;
                  end else begin
                     stack[PTR_W'(cnt)] <= C_LPAR;
                     cnt                <= cnt + CNT_W'(1);
                  end
                  T_RPAR: state <= S_PAREN;
                  T_END:  state <= S_DRAIN;
                  default: begin
                     state <= S_ERROR; ERR <= 1'b1; ERR_CODE <= E_ILL; OUT_VALID <= 1'b0;
                  end
               endcase
            end
            // Pop stronger-or-equal operators until the pending one can be pushed
            S_CMP: if (pend_wins) begin
               if (stack_full) begin
                  state <= S_ERROR; ERR <= 1'b1; ERR_CODE <= E_OVF; OUT_VALID <= 1'b0;
               end else begin
                  stack[PTR_W'(cnt)] <= pend;
                  cnt                <= cnt + CNT_W'(1);
                  state              <= S_IDLE;
               end
            end else if (out_free) begin
               OUT_VALID <= 1'b1;
               OUT_IS_OP <= 1'b1;
               OUT_DATA  <= DATA_W'(op_ascii(top));
               cnt       <= cnt - CNT_W'(1);
            end
            S_PAREN: if (stack_empty) begin
               state <= S_ERROR; ERR <= 1'b1; ERR_CODE <= E_PAREN; OUT_VALID <= 1'b0;
            end else if (top == C_LPAR) begin
               cnt   <= cnt - CNT_W'(1);
               state <= S_IDLE;
            end else if (out_free) begin
               OUT_VALID <= 1'b1;
               OUT_IS_OP <= 1'b1;
               OUT_DATA  <= DATA_W'(op_ascii(top));
               cnt       <= cnt - CNT_W'(1);
            end
            S_DRAIN: if (stack_empty) begin
               if (out_free) begin
                  DONE  <= 1'b1;
                  state <= S_IDLE;
               end
            end else if (top == C_LPAR) begin
               state <= S_ERROR; ERR <= 1'b1; ERR_CODE <= E_PAREN; OUT_VALID <= 1'b0;
            end else if (out_free) begin
               OUT_VALID <= 1'b1;
               OUT_IS_OP <= 1'b1;
               OUT_DATA  <= DATA_W'(op_ascii(top));
               cnt       <= cnt - CNT_W'(1);
            end
            default: state <= S_ERROR;
         endcase
      end
   end

endmodule

// File: tb/tb_shunting_yard.sv
// Directed bench for shunting_yard: expression table plus stall, overflow and reset sequences.
module tb_shunting_yard;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [2:0] in_type = 3'd0;
   logic [7:0] in_data = 8'd0;
   logic       out_ready = 1'b1;

   logic       b_in_ready, b_out_valid, b_out_is_op, b_done, b_busy, b_err;
   logic [7:0] b_out_data;
   logic [1:0] b_err_code;
   logic       s_in_ready, s_out_valid, s_out_is_op, s_done, s_busy, s_err;
   logic [7:0] s_out_data;
   logic [1:0] s_err_code;

   bit         sel = 1'b0;
   bit         rand_mode = 1'b0;
   logic       in_ready, out_valid, out_is_op, done, busy, err;
   logic [7:0] out_data;
   logic [1:0] err_code;

   int    checks = 0;
   int    errors = 0;
   string got = "";
   int    done_cnt = 0;
   bit    prev_stall = 1'b0;
   logic [7:0] prev_data = 8'd0;
   logic       prev_isop = 1'b0;

   always #5 clk = ~clk;

   shunting_yard #(.DATA_W(8), .DEPTH(16)) u_big (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(b_in_ready),
      .IN_TYPE(in_type), .IN_DATA(in_data), .OUT_VALID(b_out_valid),
      .OUT_READY(out_ready), .OUT_IS_OP(b_out_is_op), .OUT_DATA(b_out_data),
      .DONE(b_done), .BUSY(b_busy), .ERR(b_err), .ERR_CODE(b_err_code));

   shunting_yard #(.DATA_W(8), .DEPTH(2)) u_small (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(s_in_ready),
      .IN_TYPE(in_type), .IN_DATA(in_data), .OUT_VALID(s_out_valid),
      .OUT_READY(out_ready), .OUT_IS_OP(s_out_is_op), .OUT_DATA(s_out_data),
      .DONE(s_done), .BUSY(s_busy), .ERR(s_err), .ERR_CODE(s_err_code));

   assign in_ready  = sel ? s_in_ready  : b_in_ready;
   assign out_valid = sel ? s_out_valid : b_out_valid;
   assign out_is_op = sel ? s_out_is_op : b_out_is_op;
   assign out_data  = sel ? s_out_data  : b_out_data;
   assign done      = sel ? s_done      : b_done;
   assign busy      = sel ? s_busy      : b_busy;
   assign err       = sel ? s_err       : b_err;
   assign err_code  = sel ? s_err_code  : b_err_code;

   always @(posedge clk) begin
      #1;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Collect accepted tokens as text; numbers as digits, operators as their ASCII byte
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_stall && !err) begin
            checks++;
            if (!out_valid || out_data !== prev_data || out_is_op !== prev_isop) begin
               errors++;
               $display("FAIL stall_stable got v=%0b d=%h op=%0b expected v=1 d=%h op=%0b",
                        out_valid, out_data, out_is_op, prev_data, prev_isop);
            end
         end
         if (out_valid && out_ready)
            got = $sformatf("%s%c", got, out_is_op ? out_data : 8'(8'h30 + out_data));
         if (done) done_cnt++;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_isop  = out_is_op;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_s(input string name, input string act, input string exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got '%s' expected '%s'", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"},  int'(in_ready), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_out_is_op"}, int'(out_is_op), 0);
      chk({tag, "_out_data"},  int'(out_data), 0);
      chk({tag, "_done"},      int'(done), 0);
      chk({tag, "_busy"},      int'(busy), 0);
      chk({tag, "_err"},       int'(err), 0);
      chk({tag, "_err_code"},  int'(err_code), 0);
   endtask

   task automatic do_reset(input bit check);
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (check) chk_reset_vals("reset");
      rst = 1'b0;
      got = "";
      done_cnt = 0;
      #1;
      if (check) chk("in_ready_after_reset", int'(in_ready), 1);
   endtask

   task automatic send_tok(input byte c);
      int n;
      case (c)
         "(":     begin in_type = 3'd2; in_data = 8'd0; end
         ")":     begin in_type = 3'd3; in_data = 8'd0; end
         "E":     begin in_type = 3'd4; in_data = 8'd0; end
         "X":     begin in_type = 3'd5; in_data = 8'd0; end
         default: if (c >= "0" && c <= "9") begin
                     in_type = 3'd0; in_data = 8'(c - 8'h30);
                  end else begin
                     in_type = 3'd1; in_data = c;
                  end
      endcase
      in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (err) break;
         if (in_ready) begin
            @(posedge clk);
            #1;
            break;
         end
         n++;
         if (n > 60) begin
            checks++;
            errors++;
            $display("FAIL send_timeout token %c", c);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic send_expr(input string e);
      for (int i = 0; i < e.len(); i++) begin
         if (err) break;
         send_tok(e[i]);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_end(input string name);
      bit fin = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done_cnt > 0 || err) begin fin = 1'b1; break; end
      end
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL %s_timeout got no DONE/ERR expected one within 100 cycles", name);
      end
      repeat (4) @(negedge clk);
   endtask

   typedef struct {
      string expr;
      string exp_out;
      int    exp_err;
      int    exp_code;
      int    exp_done;
      bit    use_small;
   } vec_t;

   vec_t vecs [15];

   initial begin
      vecs[0]  = '{"3+4*2E",     "342*+",     0, 0, 1, 1'b0};
      vecs[1]  = '{"(1+2)*3E",   "12+3*",     0, 0, 1, 1'b0};
      vecs[2]  = '{"8-4-2E",     "84-2-",     0, 0, 1, 1'b0};
      vecs[3]  = '{"2^3^2E",     "232^^",     0, 0, 1, 1'b0};
      vecs[4]  = '{"1+2*3-4/2E", "123*+42/-", 0, 0, 1, 1'b0};
      vecs[5]  = '{"2*3^2/6E",   "232^*6/",   0, 0, 1, 1'b0};
      vecs[6]  = '{"E",          "",          0, 0, 1, 1'b0};
      vecs[7]  = '{"((2))E",     "2",         0, 0, 1, 1'b0};
      vecs[8]  = '{"(((",        "",          1, 1, 0, 1'b1};
      vecs[9]  = '{"1+1E",       "11+",       0, 0, 1, 1'b1};
      vecs[10] = '{")",          "",          1, 2, 0, 1'b0};
      vecs[11] = '{"(1E",        "1",         1, 2, 0, 1'b0};
      vecs[12] = '{"1)",         "1",         1, 2, 0, 1'b0};
      vecs[13] = '{"1%",         "1",         1, 3, 0, 1'b0};
      vecs[14] = '{"X",          "",          1, 3, 0, 1'b0};

      sel = 1'b0;
      do_reset(1'b1);

      foreach (vecs[k]) begin
         sel = vecs[k].use_small;
         do_reset(1'b0);
         send_expr(vecs[k].expr);
         wait_end(vecs[k].expr);
         chk_s({vecs[k].expr, "_tokens"}, got, vecs[k].exp_out);
         chk({vecs[k].expr, "_err"},      int'(err), vecs[k].exp_err);
         chk({vecs[k].expr, "_err_code"}, int'(err_code), vecs[k].exp_code);
         chk({vecs[k].expr, "_done"},     done_cnt, vecs[k].exp_done);
      end

      // Random downstream stalls on a nested expression
      sel = 1'b0;
      do_reset(1'b0);
      rand_mode = 1'b1;
      send_expr("7+6*(5-1)E");
      wait_end("stall");
      rand_mode = 1'b0;
      chk_s("stall_tokens", got, "7651-*+");
      chk("stall_done", done_cnt, 1);
      chk("stall_err", int'(err), 0);

      // Overflow on the 2-deep stack locks the input side
      sel = 1'b1;
      do_reset(1'b0);
      send_expr("(((");
      in_type = 3'd0; in_data = 8'd5; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ovf_in_ready", int'(in_ready), 0);
         chk("ovf_out_valid", int'(out_valid), 0);
         chk("ovf_err_code", int'(err_code), 1);
      end
      in_valid = 1'b0;

      // Reset while draining, then a clean expression
      sel = 1'b0;
      do_reset(1'b0);
      send_expr("1+2*3E");
      chk("middrain_busy", int'(busy), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_vals("middrain");
      rst = 1'b0;
      got = "";
      done_cnt = 0;
      send_expr("1+1E");
      wait_end("after_reset");
      chk_s("after_reset_tokens", got, "11+");
      chk("after_reset_done", done_cnt, 1);
      chk("after_reset_err", int'(err), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
